legv8_fetch_unit: RTL and testbench
===================================

Name: legv8_fetch_unit

Overview:
- IF-stage producer for the IF/ID pipeline register: owns the PC, requests instructions from instruction memory, and presents {instr, pc, valid} to IF/ID each cycle.
- Takes stall from the hazard unit and branch redirect from EX/MEM.
- Inserts NOP bubbles on memory wait or flush, so IF/ID samples clean data every posedge.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- PC_W, 64, PC and address width.
- INSTR_W, 32, instruction width.
- PC_INC, 4, byte increment per sequential fetch.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard unit: hold IF outputs and PC.
- br_taken  in  1  redirect request, one-cycle pulse.
- br_target  in  PC_W  redirect PC.
- imem_req  out  1  fetch request.
- imem_addr  out  PC_W  fetch address; equals the current PC.
- imem_ready  in  1  imem_rdata valid this cycle; completes the request.
- imem_rdata  in  INSTR_W  fetched instruction.
- if_instr  out  INSTR_W  instruction to IF/ID.
- if_pc  out  PC_W  PC of if_instr.
- if_valid  out  1  if_instr is real (0 = bubble).

Behaviour:
- Reset (synchronous, clk edge with reset=1), overrides everything:
  - pc=RESET_PC; state=IDLE; skid buffer empty.
  - if_instr=NOP (32'hD503201F); if_pc=0; if_valid=0.
  - imem_req=0 while reset is high.
  - Reset mid-transaction abandons the request; a late imem_ready is ignored.
- States: IDLE, FETCH, HOLD.
  - IDLE: imem_req=0; next state FETCH. There is exactly one dead cycle after reset.
  - FETCH: imem_req=1, imem_addr=pc. A transaction completes on a cycle where imem_req&imem_ready.
    - completion & !stall: if_instr<=imem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+PC_INC; stay FETCH. Back-to-back fetch gives 1 instr/cycle when imem_ready stays high.
    - completion & stall: capture {rdata, pc} into the skid buffer; IF outputs hold; go HOLD.
    - no completion & !stall: if_instr<=NOP, if_valid<=0, if_pc holds.
    - no completion & stall: IF outputs hold; request stays asserted.
  - HOLD: imem_req=0; IF outputs hold while stall=1.
    - stall=0: IF outputs<=skid buffer, if_valid<=1, pc<=pc+PC_INC, buffer cleared, go FETCH.
- Redirect (br_taken=1) has priority over stall and over completion:
  - pc<=br_target; if_instr<=NOP; if_valid<=0; skid buffer cleared; next state FETCH.
  - Any completion in the same cycle is discarded.
  - imem_addr=br_target appears on the following cycle.
  - Instruction memory must tolerate an abandoned request.
- Stall semantics: outputs change only on cycles with stall=0, or with br_taken=1.
- Arithmetic: pc+PC_INC is modulo 2^PC_W, so 64'hFFFF_FFFF_FFFF_FFFC wraps to 0. No carry or flag.
- Latency: rdata accepted at edge N appears on if_instr after edge N. IF/ID sees it at edge N+1.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - Extra output port align_fault (1 bit), reset 0.
  - Redirect with br_target[1:0]!=0 sets align_fault=1 (sticky until reset).
  - pc still loads br_target.
  - State goes IDLE and stays there: no further requests, IF outputs are NOP/valid=0.
- Undefined: no port; misaligned targets are fetched as given.

Decomposition:
- Package legv8_pkg:
  - NOP_INSTR constant (32'hD503201F).
  - fetch state enum {IDLE, FETCH, HOLD}.
  - PC_W / INSTR_W defaults.
- One natural sub-module: legv8_fetch_skid, a 1-entry {instr, pc} buffer with load/clear/full. The top level keeps the FSM and PC register.

Test Plan:
1. Reset, then imem_ready held 1 with rdata=addr-derived patterns:
   - first imem_req the cycle after IDLE, addr 0.
   - if_pc sequence 0, 4, 8, 12 on consecutive cycles, if_valid=1 each.
2. imem_ready low 3 cycles during FETCH, stall=0:
   - if_valid=0, if_instr=32'hD503201F for those 3 cycles.
   - pc is unchanged and imem_addr is held.
3. stall=1 on a completion cycle at pc=0x10:
   - IF outputs unchanged, imem_req=0 in HOLD.
   - After stall drops: if_pc=0x10 with the captured instr, then imem_addr=0x14.
4. br_taken=1, br_target=0x400, coincident with imem_ready=1 and stall=1:
   - response dropped, if_valid=0.
   - next imem_addr=0x400; next valid if_pc=0x400.
5. Wrap: br_target=64'hFFFF_FFFF_FFFF_FFFC, two completions → if_pc FFFF…FFFC, then 0x0.
6. Reset asserted in HOLD with a full buffer: next cycle buffer empty, state IDLE, if_valid=0, pc=RESET_PC. With FETCH_ALIGN_CHECK_EN, br_target=0x402 → align_fault=1, imem_req stays 0.

Source files
------------

// File: rtl/legv8_pkg.sv
// Shared types and constants for the LEGv8 instruction fetch slice.
package legv8_pkg;

  localparam int unsigned DEFAULT_PC_W    = 64;
  localparam int unsigned DEFAULT_INSTR_W = 32;

  localparam logic [31:0] NOP_INSTR = 32'hD503201F;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD
  } fetch_state_e;

endpackage

// File: rtl/legv8_fetch_skid.sv
// One-entry {instr, pc} buffer that parks a response which completed while IF was stalled.
module legv8_fetch_skid
  import legv8_pkg::*;
#(
  parameter int unsigned PC_W    = DEFAULT_PC_W,
  parameter int unsigned INSTR_W = DEFAULT_INSTR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               clear,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic [PC_W-1:0]    load_pc,
  output logic [INSTR_W-1:0] buf_instr,
  output logic [PC_W-1:0]    buf_pc,
  output logic               full
);

  logic [INSTR_W-1:0] instr_q;
  logic [PC_W-1:0]    pc_q;
  logic               full_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= '0;
      pc_q    <= '0;
      full_q  <= 1'b0;
    end else if (clear) begin
      full_q <= 1'b0;
    end else if (load) begin
      instr_q <= load_instr;
      pc_q    <= load_pc;
      full_q  <= 1'b1;
    end
  end

  assign buf_instr = instr_q;
  assign buf_pc    = pc_q;
  assign full      = full_q;

endmodule

// File: rtl/legv8_fetch_unit.sv
// IF stage: owns the PC, drives instruction memory and feeds IF/ID with {instr, pc, valid}.
// Optional macro FETCH_ALIGN_CHECK_EN adds a sticky align_fault on misaligned redirects.
module legv8_fetch_unit
  import legv8_pkg::*;
#(
  parameter int unsigned PC_W     = DEFAULT_PC_W,
  parameter int unsigned INSTR_W  = DEFAULT_INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned PC_INC   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               br_taken,
  input  logic [PC_W-1:0]    br_target,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  output logic               if_valid
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic               align_fault
`endif
);

  localparam logic [INSTR_W-1:0] Nop = INSTR_W'(NOP_INSTR);

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    ifpc_q, ifpc_d;
  logic               valid_q, valid_d;
  logic               fault_q, fault_d;

  logic               done;
  logic               skid_load, skid_clear, skid_full;
  logic [INSTR_W-1:0] skid_instr;
  logic [PC_W-1:0]    skid_pc;

  assign imem_req  = (state_q == FETCH) && !reset;
  assign imem_addr = pc_q;
  assign done      = imem_req && imem_ready;

  legv8_fetch_skid #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_skid (
    .clk        (clk),
    .reset      (reset),
    .load       (skid_load),
    .clear      (skid_clear),
    .load_instr (imem_rdata),
    .load_pc    (pc_q),
    .buf_instr  (skid_instr),
    .buf_pc     (skid_pc),
    .full       (skid_full)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    ifpc_d     = ifpc_q;
    valid_d    = valid_q;
    fault_d    = fault_q;
    skid_load  = 1'b0;
    skid_clear = 1'b0;

    // Redirect wins over stall and discards any response completing this cycle.
    if (br_taken) begin
      pc_d       = br_target;
      instr_d    = Nop;
      valid_d    = 1'b0;
      skid_clear = 1'b1;
      state_d    = FETCH;
`ifdef FETCH_ALIGN_CHECK_EN
      if (fault_q || (br_target[1:0] != 2'b00)) begin
        fault_d = 1'b1;
        state_d = IDLE;
      end
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = fault_q ? IDLE : FETCH;
        end
        FETCH: begin
          if (done && !stall) begin
            instr_d = imem_rdata;
            ifpc_d  = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + PC_W'(PC_INC);
          end else if (done) begin
            skid_load = 1'b1;
            state_d   = HOLD;
          end else if (!stall) begin
            instr_d = Nop;
            valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            instr_d    = skid_instr;
            ifpc_d     = skid_pc;
            valid_d    = skid_full;
            pc_d       = pc_q + PC_W'(PC_INC);
            skid_clear = 1'b1;
            state_d    = FETCH;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= Nop;
      ifpc_q  <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  assign if_instr = instr_q;
  assign if_pc    = ifpc_q;
  assign if_valid = valid_q;
`ifdef FETCH_ALIGN_CHECK_EN
  assign align_fault = fault_q;
`endif

endmodule

// File: tb/tb_legv8_fetch_unit.sv
// Self-checking bench for legv8_fetch_unit: directed scenarios plus randomized traffic vs a model.
module tb_legv8_fetch_unit;

  localparam int unsigned PC_W    = 64;
  localparam int unsigned INSTR_W = 32;
  localparam logic [63:0] RST_PC  = 64'h0;
  localparam logic [63:0] INC     = 64'd4;
  localparam logic [31:0] NOP     = 32'hD503201F;

  logic        clk, reset, stall, br_taken, imem_req, imem_ready, if_valid;
  logic [63:0] br_target, imem_addr, if_pc;
  logic [31:0] imem_rdata, if_instr;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        align_fault;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  legv8_fetch_unit #(
    .PC_W     (PC_W),
    .INSTR_W  (INSTR_W),
    .RESET_PC (RST_PC),
    .PC_INC   (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .if_valid   (if_valid)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .align_fault (align_fault)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Address-derived instruction contents so wrong addresses show up in if_instr.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return {a[15:0], ~a[17:2]} ^ a[63:32];
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  // Reference model: where fetching is, what IF/ID currently shows, and any parked response.
  typedef enum int {MIdle, MFetch, MParked} mphase_e;
  mphase_e     m_phase;
  logic [63:0] m_pc, m_ifpc, m_park_pc;
  logic [31:0] m_instr, m_park_instr;
  logic        m_valid, m_fault;

  function automatic logic [161:0] model_vec();
    logic req;
    req = !reset && (m_phase == MFetch);
    return {req, m_pc, m_valid, m_ifpc, m_instr};
  endfunction

  function automatic logic [161:0] dut_vec();
    return {imem_req, imem_addr, if_valid, if_pc, if_instr};
  endfunction

  task automatic tick();
    logic        r, s, b, rdy;
    logic [63:0] t;
    r = reset; s = stall; b = br_taken; rdy = imem_ready; t = br_target;
    @(posedge clk);
    cyc++;
    if (r) begin
      m_pc = RST_PC; m_phase = MIdle; m_instr = NOP; m_ifpc = '0; m_valid = 1'b0;
      m_fault = 1'b0;
    end else if (b) begin
      m_pc = t; m_instr = NOP; m_valid = 1'b0; m_phase = MFetch;
`ifdef FETCH_ALIGN_CHECK_EN
      if (m_fault || t[1:0] != 2'b00) begin
        m_fault = 1'b1;
        m_phase = MIdle;
      end
`endif
    end else if (m_phase == MIdle) begin
      if (!m_fault) m_phase = MFetch;
    end else if (m_phase == MFetch) begin
      if (rdy && !s) begin
        m_instr = mem_word(m_pc); m_ifpc = m_pc; m_valid = 1'b1; m_pc = m_pc + INC;
      end else if (rdy) begin
        m_park_instr = mem_word(m_pc); m_park_pc = m_pc; m_phase = MParked;
      end else if (!s) begin
        m_instr = NOP; m_valid = 1'b0;
      end
    end else if (!s) begin
      m_instr = m_park_instr; m_ifpc = m_park_pc; m_valid = 1'b1;
      m_pc = m_pc + INC; m_phase = MFetch;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; br_taken = 1'b0; imem_ready = 1'b0; br_target = '0;
    tick(); tick();
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++; $display("FAIL reset_state c%0d: got %h want %h", cyc, dut_vec(), model_vec());
    end
    checks++;
    if (if_instr !== 32'hD503201F || if_valid !== 1'b0 || if_pc !== 64'h0 || imem_req !== 1'b0)
    begin
      errors++; $display("FAIL reset_values: instr %h valid %b pc %h req %b", if_instr,
                         if_valid, if_pc, imem_req);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL dead_cycle: req %b want 0", imem_req);
    end
    imem_ready = 1'b1;
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
      errors++; $display("FAIL first_req: req %b addr %h want 1 0", imem_req, imem_addr);
    end
  endtask

  task automatic test_sequential();
    imem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL seq c%0d: got %h want %h", cyc, dut_vec(), model_vec());
      end
      checks++;
      if (if_pc !== 64'(i * 4) || if_valid !== 1'b1) begin
        errors++; $display("FAIL seq_pc %0d: pc %h valid %b want %h 1", i, if_pc, if_valid, i * 4);
      end
    end
  endtask

  task automatic test_mem_wait();
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (if_valid !== 1'b0 || if_instr !== NOP || imem_addr !== 64'h10 || imem_req !== 1'b1)
      begin
        errors++; $display("FAIL mem_wait %0d: valid %b instr %h addr %h req %b", i, if_valid,
                           if_instr, imem_addr, imem_req);
      end
    end
  endtask

  task automatic test_stall_hold();
    stall = 1'b1; imem_ready = 1'b1;
    tick();
    checks++;
    if (dut_vec() !== model_vec() || imem_req !== 1'b0 || if_valid !== 1'b0) begin
      errors++; $display("FAIL hold_enter c%0d: got %h want %h", cyc, dut_vec(), model_vec());
    end
    imem_ready = 1'($urandom_range(0, 1));
    tick();
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++; $display("FAIL hold_keep c%0d: got %h want %h", cyc, dut_vec(), model_vec());
    end
    stall = 1'b0; imem_ready = 1'b0;
    tick();
    checks++;
    if (if_pc !== 64'h10 || if_valid !== 1'b1 || if_instr !== mem_word(64'h10) ||
        imem_addr !== 64'h14 || imem_req !== 1'b1) begin
      errors++; $display("FAIL hold_release: pc %h valid %b instr %h addr %h req %b", if_pc,
                         if_valid, if_instr, imem_addr, imem_req);
    end
  endtask

  task automatic test_redirect();
    imem_ready = 1'b1; stall = 1'b1; br_taken = 1'b1; br_target = 64'h400;
    tick();
    checks++;
    if (if_valid !== 1'b0 || if_instr !== NOP || imem_addr !== 64'h400 || imem_req !== 1'b1) begin
      errors++; $display("FAIL redirect: valid %b instr %h addr %h req %b", if_valid, if_instr,
                         imem_addr, imem_req);
    end
    br_taken = 1'b0; stall = 1'b0;
    tick();
    checks++;
    if (if_pc !== 64'h400 || if_valid !== 1'b1 || dut_vec() !== model_vec()) begin
      errors++; $display("FAIL redirect_first: got %h want %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_wrap();
    br_taken = 1'b1; br_target = 64'hFFFF_FFFF_FFFF_FFFC; imem_ready = 1'b0;
    tick();
    br_taken = 1'b0; imem_ready = 1'b1;
    tick();
    checks++;
    if (if_pc !== 64'hFFFF_FFFF_FFFF_FFFC || if_valid !== 1'b1) begin
      errors++; $display("FAIL wrap_top: pc %h valid %b want fffffffffffffffc 1", if_pc, if_valid);
    end
    tick();
    checks++;
    if (if_pc !== 64'h0 || if_valid !== 1'b1 || if_instr !== mem_word(64'h0)) begin
      errors++; $display("FAIL wrap_zero: pc %h valid %b instr %h want 0 1 %h", if_pc, if_valid,
                         if_instr, mem_word(64'h0));
    end
  endtask

  task automatic test_reset_hold();
    stall = 1'b1; imem_ready = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if (imem_req !== 1'b0 || if_valid !== 1'b0 || dut_vec() !== model_vec()) begin
      errors++; $display("FAIL reset_hold: got %h want %h", dut_vec(), model_vec());
    end
    reset = 1'b0; stall = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL reset_hold_idle: req %b want 0", imem_req);
    end
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RST_PC || if_valid !== 1'b0) begin
      errors++; $display("FAIL reset_hold_resume: req %b addr %h valid %b", imem_req, imem_addr,
                         if_valid);
    end
  endtask

`ifdef FETCH_ALIGN_CHECK_EN
  task automatic test_align();
    imem_ready = 1'b1; br_taken = 1'b1; br_target = 64'h402;
    tick();
    br_taken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (align_fault !== 1'b1 || imem_req !== 1'b0 || if_valid !== 1'b0 ||
          dut_vec() !== model_vec()) begin
        errors++; $display("FAIL align %0d: fault %b req %b valid %b", i, align_fault, imem_req,
                           if_valid);
      end
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (align_fault !== 1'b0) begin
      errors++; $display("FAIL align_reset: fault %b want 0", align_fault);
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset      = ($urandom_range(0, 99) < 2);
      stall      = ($urandom_range(0, 99) < 30);
      imem_ready = ($urandom_range(0, 99) < 60);
      br_taken   = ($urandom_range(0, 99) < 6);
      br_target  = {$urandom, $urandom} & ~64'h3;
      tick();
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL random c%0d: got %h want %h", cyc, dut_vec(), model_vec());
      end
    end
    reset = 1'b0; stall = 1'b0; br_taken = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_mem_wait();
    test_stall_hold();
    test_redirect();
    test_wrap();
    test_reset_hold();
`ifdef FETCH_ALIGN_CHECK_EN
    test_align();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

endmodule
